// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side datapath muxes: arbitration mode codes
// and a ceiling-log2 helper for tools that lack $clog2.
package cpu_pkg;

  localparam int MUX_MODE_RR    = 0;
  localparam int MUX_MODE_FIXED = 1;

  // Smallest w with 2**w >= n (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational N-way arbiter. Round-robin scans upward from ptr+1 with
// wrap; fixed priority scans from index 0 so the lowest requester wins.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic found;
  int   start;
  int   idx;

  assign any = |req;

  // Scan the channels in priority order and keep the first requester found.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    if (mode == 1'(MUX_MODE_FIXED)) begin
      start = 0;
    end else begin
      start = (int'(ptr) + 1) % N;
    end
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_idx         = SELW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready mux with a single-entry registered output stage.
// The output register reloads whenever it is empty or being drained, so a
// continuously accepting sink sees one transfer per cycle with no bubbles.
module rr_mux_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan_data [N];
  logic [N-1:0]     gnt_onehot;
  logic [SELW-1:0]  gnt_idx;
  logic             any_req;
  logic             load_en;
  logic             xfer;

  logic [SELW-1:0]  ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_sel_reg;

  // Unpack the flat data bus into one word per channel.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr_reg),
    .mode       (MODE == MUX_MODE_FIXED),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // out_ready reaches in_ready combinationally; it never reaches the outputs.
  assign load_en  = !out_valid_reg || out_ready;
  assign xfer     = load_en && any_req && !rst;
  assign in_ready = xfer ? gnt_onehot : '0;

  // Output stage and round-robin pointer; the pointer moves only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= SELW'(N - 1);
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[gnt_idx];
        out_sel_reg   <= gnt_idx;
        if (MODE == MUX_MODE_RR) begin
          ptr_reg <= gnt_idx;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: a round-robin and a fixed-priority instance share the
// same producers and sink, each checked against a transaction-level model.
module tb_rr_mux_reg;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       in_valid = '0;
  logic [N*WIDTH-1:0] in_data  = '0;
  logic               out_ready = 1'b0;

  logic [N-1:0]       rdy_rr, rdy_fx;
  logic               vld_rr, vld_fx;
  logic [WIDTH-1:0]   dat_rr, dat_fx;
  logic [SELW-1:0]    sel_rr, sel_fx;

  int errors = 0;
  int checks = 0;

  // Model state: index 0 = round-robin, 1 = fixed priority.
  bit               m_valid [2];
  logic [WIDTH-1:0] m_data  [2];
  int               m_sel   [2];
  int               m_ptr   [2];

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(vld_rr), .out_data(dat_rr),
    .out_sel(sel_rr), .out_ready(out_ready));

  rr_mux_reg #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fx), .out_valid(vld_fx), .out_data(dat_fx),
    .out_sel(sel_fx), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int grant(input int m, input logic [N-1:0] v);
    if (v == '0) return -1;
    if (m == 1) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (v[(m_ptr[0] + k) % N]) return (m_ptr[0] + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int g;
    g = grant(m, in_valid);
    if ((!m_valid[m] || out_ready) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = '0; m_sel[m] = 0; m_ptr[m] = N - 1;
    end
  endtask

  task automatic model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = grant(m, in_valid);
      if ((!m_valid[m] || out_ready) && g >= 0) begin
        m_valid[m] = 1;
        m_data[m]  = in_data[g*WIDTH +: WIDTH];
        m_sel[m]   = g;
        if (m == 0) m_ptr[m] = g;
      end else if (out_ready) begin
        m_valid[m] = 0;
      end
    end
  endtask

  task automatic check_out();
    chk("rr_valid", 64'(vld_rr), 64'(m_valid[0]));
    chk("rr_data",  64'(dat_rr), 64'(m_data[0]));
    chk("rr_sel",   64'(sel_rr), 64'(m_sel[0]));
    chk("fx_valid", 64'(vld_fx), 64'(m_valid[1]));
    chk("fx_data",  64'(dat_fx), 64'(m_data[1]));
    chk("fx_sel",   64'(sel_fx), 64'(m_sel[1]));
  endtask

  // Inputs are set at the negedge by the caller; one clock is then run.
  task automatic cycle();
    #1;
    chk("rr_ready", 64'(rdy_rr), 64'(exp_ready(0)));
    chk("fx_ready", 64'(rdy_fx), 64'(exp_ready(1)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out();
    $display("cyc t=%0t valid=%b ordy=%b | rr v=%0d sel=%0d d=%h | fx v=%0d sel=%0d d=%h",
             $time, in_valid, out_ready, vld_rr, sel_rr, dat_rr, vld_fx, sel_fx, dat_fx);
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_out();
    chk("reset_rdy", 64'(rdy_rr | rdy_fx), 64'(0));
    rst = 1'b0;

    // Round-robin fairness with every channel requesting.
    for (int i = 0; i < N; i++) set_data(i, WIDTH'(32'hA0 + i));
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("fair_sel", 64'(sel_rr), 64'(k % 4));
      chk("fair_data", 64'(dat_rr), 64'(32'hA0 + (k % 4)));
    end

    // Asynchronous reset with a loaded output register.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(vld_rr), 64'(0));
    chk("arst_data",  64'(dat_rr), 64'(0));
    chk("arst_sel",   64'(sel_rr), 64'(0));
    chk("arst_rdy",   64'(rdy_rr), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_rst_sel", 64'(sel_rr), 64'(0));

    // Fixed priority: channel 1 starves channel 3 until it drops.
    do_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("fixed_sel1", 64'(sel_fx), 64'(1));
    end
    in_valid = 4'b1000;
    cycle();
    chk("fixed_sel3", 64'(sel_fx), 64'(3));

    // Backpressure after loading 0x55 from channel 2.
    do_reset();
    set_data(2, 32'h55);
    in_valid = 4'b0100; out_ready = 1'b0;
    cycle();
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", 64'(dat_rr), 64'(32'h55));
      chk("bp_sel",  64'(sel_rr), 64'(2));
      chk("bp_rdy",  64'(rdy_rr), 64'(0));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_valid", 64'(vld_rr), 64'(1));
    chk("bp_next_sel",   64'(sel_rr), 64'(3));

    // Wrap/skip with ptr at 2.
    do_reset();
    in_valid = 4'b0100;
    cycle();
    in_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wrap_sel", 64'(sel_rr), 64'((k % 2 == 0) ? 0 : 1));
    end

    // Sparse pulse then drain.
    do_reset();
    set_data(3, 32'h1234);
    in_valid = 4'b1000;
    cycle();
    chk("sparse_valid", 64'(vld_rr), 64'(1));
    in_valid = 4'b0000;
    cycle();
    chk("drain_valid", 64'(vld_rr), 64'(0));
    chk("drain_data",  64'(dat_rr), 64'(32'h1234));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_data(i, WIDTH'($urandom));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel successor to the two-, three- and four-input datapath muxes.
- Selects one of N valid/ready producer channels by round-robin or fixed priority.
- Registers the winner into a single-entry output stage with valid/ready backpressure.
- Used wherever several CPU-side sources share one sink: writeback port, memory request bus, debug tap.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, channel count; legal range 2..16.
- MODE, 0, 0 = round-robin, 1 = fixed priority with lowest index winning.
- SELW, $clog2(N), width of the grant index. Derived; never overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  per-channel request.
- in_data  in  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept; one-hot or zero.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SELW  index of the channel that produced out_data.
- out_ready  in  1  sink accept.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, rr pointer=N-1, so channel 0 has priority first. in_ready is 0 while rst is high.
- load_en = !out_valid | out_ready. This is combinational; it gives full throughput with no bubble when draining.
- Grant, combinational:
  - MODE 0: first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... modulo N, with wrap from N-1 to 0.
  - MODE 1: lowest i with in_valid[i]=1.
- in_ready[g] = load_en & any(in_valid) for grant g. All other in_ready bits are 0. in_ready never asserts for a channel whose in_valid=0.
- Transfer on channel g when in_valid[g] & in_ready[g]. At the next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1. In MODE 0, ptr <= g.
- Pointer rule: ptr updates only on a transfer. A cycle without a transfer leaves ptr unchanged.
- Drain: out_valid & out_ready with no new transfer gives out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load: new data replaces old in the same edge and out_valid stays 1.
- Backpressure stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid hold stable. All in_ready bits are 0.
- Latency: 1 cycle from input handshake to out_valid. Throughput is 1 transfer/cycle.
- Producers may drop in_valid without a handshake. The arbiter has no memory of unserved requests beyond ptr.
- Reset mid-operation: any pending output is discarded and ptr returns to N-1.
- No combinational path from out_ready to out_valid/out_data. There is a combinational path from out_ready to in_ready.

Decomposition:
- Shared package, cpu_pkg:
  - constants MUX_MODE_RR=0 and MUX_MODE_FIXED=1;
  - a clog2 helper function when the tool lacks $clog2.
- One sub-module, rr_arbiter:
  - purely combinational;
  - inputs: req[N], ptr[SELW], mode;
  - outputs: gnt_onehot[N], gnt_idx[SELW], any.
- rr_mux_reg owns the pointer and output registers.

Test Plan:
- Reset/idle: assert rst mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately, and channel 0 wins the first request after release.
- RR fairness: N=4, MODE 0, all in_valid=1 with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0,1, one per cycle, out_data matching each channel.
- Fixed priority: MODE 1, in_valid=4'b1010 with out_ready=1 -> out_sel=1 every cycle; channel 3 is never granted until in_valid[1] drops, then out_sel=3.
- Backpressure: out_ready=0 for 5 cycles after the first load of 0x55 from channel 2 -> out_data=0x55 and out_sel=2 hold stable, in_ready=0; on out_ready=1, the next grant loads the following cycle with no bubble.
- Wrap/skip: ptr=2, in_valid=4'b0011 -> grant is channel 0, then channel 1, then channel 0.
- Sparse/drain: a single in_valid pulse on channel 3 with data 0x1234 -> out_valid=1 for one cycle with out_ready=1, then 0, with out_data retaining 0x1234.
